// File: rtl/cpu_types_pkg.sv
// Shared definitions for the 5-stage datapath control blocks: hazard states,
// opcodes and the latch-control bundle driven by the hazard unit.
package cpu_types_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_DWAIT    = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    typedef enum logic [1:0] {
        RUN      = ST_RUN,
        LU_STALL = ST_LU_STALL,
        DWAIT    = ST_DWAIT,
        HALTED   = ST_HALTED
    } hz_state_t;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] HALT  = 6'b111111;

    localparam logic [1:0] REGSEL_LOAD = 2'b11;

    typedef struct packed {
        logic pc_en;
        logic en_fd;
        logic en_de;
        logic en_em;
        logic en_mw;
        logic flush_fd;
        logic flush_de;
    } hz_ctrl_t;

    function automatic hz_ctrl_t ctrl_freeze();
        hz_ctrl_t c;
        c = '0;
        return c;
    endfunction

    // Front end held, back end drains, and a bubble is loaded into DE.
    function automatic hz_ctrl_t ctrl_bubble();
        hz_ctrl_t c;
        c          = '0;
        c.en_em    = 1'b1;
        c.en_mw    = 1'b1;
        c.flush_de = 1'b1;
        return c;
    endfunction

    function automatic hz_ctrl_t ctrl_advance(input logic taken);
        hz_ctrl_t c;
        c          = '0;
        c.pc_en    = 1'b1;
        c.en_fd    = 1'b1;
        c.en_de    = 1'b1;
        c.en_em    = 1'b1;
        c.en_mw    = 1'b1;
        c.flush_fd = taken;
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard_unit signals; hu is the controller's view, tb the driver's.
interface hazard_unit_if #(
    parameter int CNT_W = 32
) (
    input logic CLK
);
    logic             RST;
    logic             ihit;
    logic             dhit;
    logic             dmemREN_me;
    logic             dmemWEN_me;
    logic             halt_me;
    logic [31:0]      instru_de;
    logic [4:0]       regDst_ex;
    logic             regWr_ex;
    logic [1:0]       regSel_ex;
    logic             taken_de;
    logic             pc_en;
    logic             en_fd;
    logic             en_de;
    logic             en_em;
    logic             en_mw;
    logic             flush_fd;
    logic             flush_de;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport hu (
        input  CLK, RST, ihit, dhit, dmemREN_me, dmemWEN_me, halt_me,
               instru_de, regDst_ex, regWr_ex, regSel_ex, taken_de,
        output pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de,
               halt, stall_cnt
    );

    modport tb (
        input  CLK, pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de,
               halt, stall_cnt,
        output RST, ihit, dhit, dmemREN_me, dmemWEN_me, halt_me,
               instru_de, regDst_ex, regWr_ex, regSel_ex, taken_de
    );
endinterface

// File: rtl/hazard_unit_lu_detect.sv
// Load-use detection: a load in EX whose destination is read by the
// instruction sitting in DE, which forwarding cannot cover.
module lu_detect
    import cpu_types_pkg::*;
(
    input  logic [31:0] instru_de,
    input  logic [4:0]  regDst_ex,
    input  logic        regWr_ex,
    input  logic [1:0]  regSel_ex,
    output logic        lu
);

    logic [5:0] opcode;
    logic [4:0] rs_de;
    logic [4:0] rt_de;
    logic       rt_used;
    logic       load_ex;
    logic       unused_imm;

    assign opcode     = instru_de[31:26];
    assign rs_de      = instru_de[25:21];
    assign rt_de      = instru_de[20:16];
    assign unused_imm = ^instru_de[15:0];

    // rt is a source only for R-type ALU ops, branches and stores; for other
    // I-types it is the destination and must not trigger a stall.
    assign rt_used = (opcode == RTYPE) || (opcode == BEQ) ||
                     (opcode == BNE)   || (opcode == SW);

    assign load_ex = regWr_ex && (regSel_ex == REGSEL_LOAD) && (regDst_ex != 5'd0);

    assign lu = load_ex && ((rs_de == regDst_ex) || (rt_used && (rt_de == regDst_ex)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard and stall controller: load-use bubbles, memory wait states,
// decode-resolved control transfers and halt drain for the 5-stage datapath.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int LU_BUBBLES = 2,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_me,
    input  logic             dmemWEN_me,
    input  logic             halt_me,
    input  logic [31:0]      instru_de,
    input  logic [4:0]       regDst_ex,
    input  logic             regWr_ex,
    input  logic [1:0]       regSel_ex,
    input  logic             taken_de,
    output logic             pc_en,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0]       LU_INIT = 2'(LU_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hz_state_t  state;
    hz_state_t  state_nxt;
    logic [1:0] lu_cnt;
    logic [1:0] lu_cnt_nxt;
    logic       halt_nxt;
    logic       lu;
    logic       mem_wait;
    logic       cnt_en;
    hz_ctrl_t   ctrl;
    hz_ctrl_t   ctrl_out;

    lu_detect u_lu_detect (
        .instru_de (instru_de),
        .regDst_ex (regDst_ex),
        .regWr_ex  (regWr_ex),
        .regSel_ex (regSel_ex),
        .lu        (lu)
    );

    assign mem_wait = (dmemREN_me || dmemWEN_me) && !dhit;

    always_comb begin
        ctrl       = ctrl_freeze();
        state_nxt  = state;
        lu_cnt_nxt = lu_cnt;
        halt_nxt   = halt;

        case (state)
            RUN: begin
                if (halt_me) begin
                    state_nxt = HALTED;
                    halt_nxt  = 1'b1;
                end else if (mem_wait) begin
                    state_nxt = DWAIT;
                end else if (!ihit) begin
                    state_nxt = RUN;
                end else if (lu) begin
                    // A taken transfer alongside a load-use is dropped here and
                    // re-resolves in decode once the bubbles have drained.
                    ctrl       = ctrl_bubble();
                    lu_cnt_nxt = LU_INIT;
                    state_nxt  = (LU_BUBBLES > 1) ? LU_STALL : RUN;
                end else begin
                    ctrl = ctrl_advance(taken_de);
                end
            end

            LU_STALL: begin
                if (!mem_wait) begin
                    ctrl = ctrl_bubble();
                    if (lu_cnt <= 2'd1) begin
                        lu_cnt_nxt = 2'd0;
                        state_nxt  = RUN;
                    end else begin
                        lu_cnt_nxt = lu_cnt - 2'd1;
                    end
                end
            end

            DWAIT: begin
                if (halt_me) begin
                    state_nxt = HALTED;
                    halt_nxt  = 1'b1;
                end else if (dhit) begin
                    if (lu) begin
                        ctrl       = ctrl_bubble();
                        lu_cnt_nxt = LU_INIT;
                        state_nxt  = (LU_BUBBLES > 1) ? LU_STALL : RUN;
                    end else begin
                        ctrl      = ctrl_advance(taken_de);
                        state_nxt = RUN;
                    end
                end
            end

            HALTED: begin
                halt_nxt = 1'b1;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Strobes are forced low while reset is held so no latch captures garbage.
    always_comb begin
        ctrl_out = ctrl;
        if (RST) begin
            ctrl_out = ctrl_freeze();
        end
    end

    assign pc_en    = ctrl_out.pc_en;
    assign en_fd    = ctrl_out.en_fd;
    assign en_de    = ctrl_out.en_de;
    assign en_em    = ctrl_out.en_em;
    assign en_mw    = ctrl_out.en_mw;
    assign flush_fd = ctrl_out.flush_fd;
    assign flush_de = ctrl_out.flush_de;

    assign cnt_en = !ctrl.en_de && (state != HALTED) && (stall_cnt != CNT_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            lu_cnt    <= 2'd0;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
            halt   <= halt_nxt;
            if (cnt_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: per-cycle vector tables checked through
// an expectation queue, plus hand-written reset and saturation sequences.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        ihit;
        logic        dhit;
        logic        ren;
        logic        wen;
        logic        halt_me;
        logic        taken;
        logic        wr;
        logic [1:0]  sel;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [6:0]  exp_ctrl;
        logic        exp_halt;
        logic [31:0] exp_cnt;
    } vec_t;

    // {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de}
    localparam logic [6:0] C_RUN   = 7'b1111100;
    localparam logic [6:0] C_TAKEN = 7'b1111110;
    localparam logic [6:0] C_BUB   = 7'b0001101;
    localparam logic [6:0] C_FRZ   = 7'b0000000;

    localparam logic [31:0] I_NOP     = {6'b000000, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
    localparam logic [31:0] I_ADD_RS5 = {6'b000000, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20};
    localparam logic [31:0] I_ADD_RT5 = {6'b000000, 5'd3, 5'd5, 5'd7, 5'd0, 6'h20};
    localparam logic [31:0] I_ADD_R0  = {6'b000000, 5'd0, 5'd0, 5'd7, 5'd0, 6'h20};
    localparam logic [31:0] I_ADDI_RT5 = {6'b001000, 5'd3, 5'd5, 16'd4};
    localparam logic [31:0] I_LW_RS5  = {6'b100011, 5'd5, 5'd8, 16'd0};
    localparam logic [31:0] I_SW_RT5  = {6'b101011, 5'd3, 5'd5, 16'd8};
    localparam logic [31:0] I_BEQ_RT5 = {6'b000100, 5'd3, 5'd5, 16'd2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if hif (.CLK(clk));

    logic       sat_pc_en, sat_en_fd, sat_en_de, sat_en_em, sat_en_mw;
    logic       sat_flush_fd, sat_flush_de, sat_halt;
    logic [2:0] sat_cnt;

    hazard_unit dut (
        .CLK        (clk),
        .RST        (hif.RST),
        .ihit       (hif.ihit),
        .dhit       (hif.dhit),
        .dmemREN_me (hif.dmemREN_me),
        .dmemWEN_me (hif.dmemWEN_me),
        .halt_me    (hif.halt_me),
        .instru_de  (hif.instru_de),
        .regDst_ex  (hif.regDst_ex),
        .regWr_ex   (hif.regWr_ex),
        .regSel_ex  (hif.regSel_ex),
        .taken_de   (hif.taken_de),
        .pc_en      (hif.pc_en),
        .en_fd      (hif.en_fd),
        .en_de      (hif.en_de),
        .en_em      (hif.en_em),
        .en_mw      (hif.en_mw),
        .flush_fd   (hif.flush_fd),
        .flush_de   (hif.flush_de),
        .halt       (hif.halt),
        .stall_cnt  (hif.stall_cnt)
    );

    hazard_unit #(.LU_BUBBLES(2), .CNT_W(3)) dut_sat (
        .CLK        (clk),
        .RST        (hif.RST),
        .ihit       (hif.ihit),
        .dhit       (hif.dhit),
        .dmemREN_me (hif.dmemREN_me),
        .dmemWEN_me (hif.dmemWEN_me),
        .halt_me    (hif.halt_me),
        .instru_de  (hif.instru_de),
        .regDst_ex  (hif.regDst_ex),
        .regWr_ex   (hif.regWr_ex),
        .regSel_ex  (hif.regSel_ex),
        .taken_de   (hif.taken_de),
        .pc_en      (sat_pc_en),
        .en_fd      (sat_en_fd),
        .en_de      (sat_en_de),
        .en_em      (sat_en_em),
        .en_mw      (sat_en_mw),
        .flush_fd   (sat_flush_fd),
        .flush_de   (sat_flush_de),
        .halt       (sat_halt),
        .stall_cnt  (sat_cnt)
    );

    int   checks   = 0;
    int   failures = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic logic [6:0] ctrlBits();
        return {hif.pc_en, hif.en_fd, hif.en_de, hif.en_em, hif.en_mw,
                hif.flush_fd, hif.flush_de};
    endfunction

    function automatic vec_t mk(input logic ih, input logic dh, input logic rn,
                                input logic wn, input logic hm, input logic tk,
                                input logic wr, input logic [1:0] sel,
                                input logic [4:0] dst, input logic [31:0] ins,
                                input logic [6:0] ec, input logic eh, input int cnt);
        vec_t v;
        v.ihit     = ih;
        v.dhit     = dh;
        v.ren      = rn;
        v.wen      = wn;
        v.halt_me  = hm;
        v.taken    = tk;
        v.wr       = wr;
        v.sel      = sel;
        v.dst      = dst;
        v.instr    = ins;
        v.exp_ctrl = ec;
        v.exp_halt = eh;
        v.exp_cnt  = cnt;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic driveIdle();
        hif.ihit       = 1'b1;
        hif.dhit       = 1'b0;
        hif.dmemREN_me = 1'b0;
        hif.dmemWEN_me = 1'b0;
        hif.halt_me    = 1'b0;
        hif.taken_de   = 1'b0;
        hif.regWr_ex   = 1'b0;
        hif.regSel_ex  = 2'b00;
        hif.regDst_ex  = 5'd0;
        hif.instru_de  = I_NOP;
    endtask

    task automatic applyStimulus(input vec_t v);
        hif.ihit       = v.ihit;
        hif.dhit       = v.dhit;
        hif.dmemREN_me = v.ren;
        hif.dmemWEN_me = v.wen;
        hif.halt_me    = v.halt_me;
        hif.taken_de   = v.taken;
        hif.regWr_ex   = v.wr;
        hif.regSel_ex  = v.sel;
        hif.regDst_ex  = v.dst;
        hif.instru_de  = v.instr;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string nm);
        vec_t e;
        if (exp_q.size() == 0) begin
            cmp({nm, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            cmp({nm, ".ctrl"}, {25'd0, ctrlBits()}, {25'd0, e.exp_ctrl});
            cmp({nm, ".halt"}, {31'd0, hif.halt}, {31'd0, e.exp_halt});
            cmp({nm, ".cnt"}, hif.stall_cnt, e.exp_cnt);
        end
    endtask

    // Each entry is one clock: drive after the edge, check at the falling edge.
    task automatic runSeq(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("%s%0d", tag, i));
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic resetDut(input string tag);
        hif.RST = 1'b1;
        driveIdle();
        #2;
        cmp({tag, ".rst_ctrl"}, {25'd0, ctrlBits()}, 32'd0);
        cmp({tag, ".rst_halt"}, {31'd0, hif.halt}, 32'd0);
        cmp({tag, ".rst_cnt"}, hif.stall_cnt, 32'd0);
        @(negedge clk);
        hif.RST = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetDut("init");

        // Load then dependent add through rs: two bubbles, then free running.
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_ADD_RS5, C_BUB, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_ADD_RS5, C_BUB, 0, 1));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_ADD_RS5, C_RUN, 0, 2));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 2));
        runSeq("A");

        resetDut("rB");
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_ADDI_RT5, C_RUN, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd0, I_ADD_R0,   C_RUN, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b11,5'd5, I_ADD_RS5,  C_RUN, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b01,5'd5, I_ADD_RS5,  C_RUN, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_LW_RS5,   C_BUB, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_LW_RS5,   C_BUB, 0, 1));
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_SW_RT5,   C_BUB, 0, 2));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_SW_RT5,   C_BUB, 0, 3));
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_BEQ_RT5,  C_BUB, 0, 4));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_BEQ_RT5,  C_BUB, 0, 5));
        tbl.push_back(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_ADD_RT5,  C_BUB, 0, 6));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_ADD_RT5,  C_BUB, 0, 7));
        tbl.push_back(mk(1,0,0,0,0,1, 0,2'b00,5'd0, I_NOP,      C_TAKEN, 0, 8));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,      C_RUN, 0, 8));
        runSeq("B");

        resetDut("rC");
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_NOP,     C_FRZ, 0, 0));
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_NOP,     C_FRZ, 0, 1));
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_NOP,     C_FRZ, 0, 2));
        tbl.push_back(mk(1,1,1,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 3));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 3));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_FRZ, 0, 3));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 4));
        tbl.push_back(mk(1,0,0,1,0,0, 0,2'b00,5'd0, I_NOP,     C_FRZ, 0, 4));
        tbl.push_back(mk(1,1,0,1,0,1, 1,2'b11,5'd5, I_ADD_RS5, C_BUB, 0, 5));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_ADD_RS5, C_BUB, 0, 6));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 7));
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_NOP,     C_FRZ, 0, 7));
        tbl.push_back(mk(1,1,1,0,0,1, 0,2'b00,5'd0, I_NOP,     C_TAKEN, 0, 8));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 8));
        runSeq("C");

        resetDut("rD");
        tbl.push_back(mk(1,0,0,0,0,1, 1,2'b11,5'd5, I_ADD_RS5, C_BUB, 0, 0));
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_ADD_RS5, C_FRZ, 0, 1));
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_ADD_RS5, C_FRZ, 0, 2));
        tbl.push_back(mk(1,1,1,0,0,0, 0,2'b00,5'd0, I_ADD_RS5, C_BUB, 0, 3));
        tbl.push_back(mk(1,0,0,0,0,1, 0,2'b00,5'd0, I_ADD_RS5, C_TAKEN, 0, 4));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP,     C_RUN, 0, 4));
        runSeq("D");

        resetDut("rF");
        tbl.push_back(mk(1,0,0,0,1,0, 0,2'b00,5'd0, I_NOP, C_FRZ, 0, 0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,2'b00,5'd0, I_NOP, C_FRZ, 1, 1));
        tbl.push_back(mk(1,0,0,0,0,1, 0,2'b00,5'd0, I_NOP, C_FRZ, 1, 1));
        runSeq("F");

        resetDut("rE");
        tbl.push_back(mk(1,0,1,0,0,0, 0,2'b00,5'd0, I_NOP, C_FRZ, 0, 0));
        tbl.push_back(mk(1,0,1,0,1,0, 0,2'b00,5'd0, I_NOP, C_FRZ, 0, 1));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(1,1,0,0,0,0, 1,2'b11,5'd5, I_ADD_RS5, C_FRZ, 1, 2));
        end
        runSeq("E");

        // Reset pulse after halt must clear halt and the stall count.
        resetDut("rE2");

        // Asynchronous reset inside a load-use stall, released before any edge.
        applyStimulus(mk(1,0,0,0,0,0, 1,2'b11,5'd5, I_ADD_RS5, C_BUB, 0, 0));
        @(negedge clk);
        checkOutput("R0");
        @(posedge clk);
        #1;
        driveIdle();
        cmp("R.pre_cnt", hif.stall_cnt, 32'd1);
        cmp("R.pre_ctrl", {25'd0, ctrlBits()}, {25'd0, C_BUB});
        #1;
        hif.RST = 1'b1;
        #1;
        cmp("R.async_ctrl", {25'd0, ctrlBits()}, 32'd0);
        cmp("R.async_cnt", hif.stall_cnt, 32'd0);
        #1;
        hif.RST = 1'b0;
        #1;
        cmp("R.release_ctrl", {25'd0, ctrlBits()}, {25'd0, C_RUN});
        cmp("R.release_cnt", hif.stall_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Ten fetch-wait cycles: the 3-bit counter must pin at 7.
        resetDut("rS");
        hif.ihit = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        hif.ihit = 1'b1;
        #1;
        cmp("S.main_cnt", hif.stall_cnt, 32'd10);
        cmp("S.sat_cnt", {29'd0, sat_cnt}, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage datapath. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, since the load result is not forwarded from MEM into EX; instruction and data memory wait states; decode-resolved control transfers; and halt drain. It produces per-latch enable and flush strobes, plus the PC enable and a stall counter.

## Interface
Parameters:
- `LU_BUBBLES`, default 2: bubbles inserted on a load-use hazard (EX→MEM distance plus the missing MEM load forward).
- `CNT_W`, default 32: stall counter width.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `ihit` in 1: imem returned instruction this cycle.
- `dhit` in 1: dmem access completed this cycle.
- `dmemREN_me`, `dmemWEN_me` in 1 each: MEM-stage memory request.
- `halt_me` in 1: HALT opcode in MEM.
- `instru_de` in 32: instruction in DE latch.
- `regDst_ex` in 5, `regWr_ex` in 1, `regSel_ex` in 2: EX-stage writeback info; `regSel` = 2'b11 means load.
- `taken_de` in 1: decode resolved jump/JR/branch taken.
- `pc_en`, `en_fd`, `en_de`, `en_em`, `en_mw` out 1 each: latch enables.
- `flush_fd` out 1: clear FD on next edge.
- `flush_de` out 1: load bubble into DE.
- `halt` out 1: sticky halt.
- `stall_cnt` out `CNT_W`: stalled-cycle count.

## Operation
- States: RUN, LU_STALL, DWAIT, HALTED. `lu_cnt` is a 2-bit down-counter.
- Definitions:
  - `rs_de` = `instru_de[25:21]`; `rt_de` = `instru_de[20:16]`.
  - `rt_used` = opcode is RTYPE, BEQ, BNE or SW.
  - `load_ex` = `regWr_ex` & (`regSel_ex`==2'b11) & (`regDst_ex`≠0).
  - `lu` = `load_ex` & (`rs_de`==`regDst_ex` | (`rt_used` & `rt_de`==`regDst_ex`)).
  - `memreq` = `dmemREN_me` | `dmemWEN_me`.
- RUN, evaluated in priority order (first match wins):
  1. `halt_me`: all enables 0; next state HALTED; `halt` set.
  2. `memreq` & !`dhit`: all enables 0; next state DWAIT.
  3. !`ihit`: all enables 0; stay in RUN.
  4. `lu`: `pc_en`/`en_fd`/`en_de` = 0, `en_em`/`en_mw` = 1, `flush_de` = 1; `lu_cnt` ← `LU_BUBBLES`-1; next state LU_STALL. `taken_de` is ignored.
  5. Otherwise: all enables 1; `flush_fd` = `taken_de`.
- LU_STALL: same outputs as rule 4, but `lu_cnt` decrements. When `lu_cnt`==0 the controller returns to RUN. If `memreq` & !`dhit` occurs, everything freezes and `lu_cnt` holds.
- DWAIT: all enables 0. On `dhit` all enables become 1 and the next state is RUN; the same cycle also applies `taken_de`/`lu` as in RUN rules 4 and 5.
- HALTED: all enables 0 and `halt`=1 until `RST`.
- `stall_cnt` increments on every cycle in which `en_de`=0 and state≠HALTED. It saturates at all-ones and does not wrap.

## Timing
- Reset values, while `RST` is high and after it deasserts:
  - State RUN, `lu_cnt`=0, `halt`=0, `stall_cnt`=0.
  - All enables and flushes are driven 0 while `RST` is high.
- Enables and flushes are combinational from the current state and inputs and take effect at the next edge. State, `halt` and `stall_cnt` are registered, with zero added latency to the pipeline.
- A load-use hazard costs exactly `LU_BUBBLES` cycles (2) of frozen fetch/decode when memory has no waits.
- `halt` rises one edge after `halt_me` is seen in RUN.
- `taken_de` together with `lu` results in a stall with no flush; the branch re-resolves once the stall releases.
- `RST` asserted mid-stall clears the state immediately (asynchronous).

## Structure
- `cpu_types_pkg` holds the shared definitions:
  - `hz_state_t` enum.
  - Opcode constants RTYPE, BEQ, BNE, SW, HALT.
  - `REGSEL_LOAD` = 2'b11.
- `hazard_unit_if` carries the ports, with modports `hu` and `tb`.
- One sub-module, `lu_detect`, holds the combinational `lu`/`rt_used` decode.

## Test plan
- Load then dependent add: `load_ex`, `regDst_ex`=5, `instru_de` add with rs=5, `ihit`=1.
  - Expect `pc_en`/`en_fd`/`en_de` = 0 and `flush_de` = 1 for exactly 2 cycles, then all enables 1.
  - Expect `stall_cnt`=2.
- Load then I-type using rt=`regDst_ex` (addi): expect no stall. The same case with `regDst_ex`=0: expect no stall.
- `dmemREN_me`=1 with `dhit` low for 3 cycles:
  - All enables 0 during DWAIT.
  - Enables return to 1 on the `dhit` cycle.
  - `stall_cnt`=3.
- `taken_de`=1, no hazard, `ihit`=1: `flush_fd`=1 for one cycle. `taken_de`=1 during `lu`: `flush_fd`=0.
- `halt_me`=1 during a data wait: `halt` goes to 1 next cycle and enables stay 0 for 10 cycles. `RST` pulse then clears `halt` and `stall_cnt`.
- `RST` asserted in the second LU_STALL cycle: state returns to RUN asynchronously and outputs are 0 until release.
